// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between the fetch
//   stage (instruction line reads) and the memory stage (data reads/writes).
//   One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
//   Data requests win over fetch, except that fetch is granted once data has
//   won STARVE_MAX consecutive grants while fetch was waiting.
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   f_req/f_addr/f_flush       fetch request, address, cancel of in-flight fetch
//   f_done/f_line/f_err        fetch completion pulse, 80-bit line, error flag
//   d_req/d_we/d_addr/d_wdata  data request
//   d_done/d_rdata/d_err       data completion pulse, read data, error flag
//   mem_req/we/addr/wdata      one-cycle issue strobe and command to memory
//   mem_rvalid/rdata/err       memory response
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_W     = 80,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_done,
    output logic [LINE_W-1:0] f_line,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;     // 1 = data owns the transaction
    logic              we_q, we_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              flush_q, flush_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic              f_done_q, f_done_d;
    logic [LINE_W-1:0] f_line_q, f_line_d;
    logic              f_err_q, f_err_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              grant_data;
    logic              timed_out;
    logic              rsp_err;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        streak_d    = streak_q;
        flush_d     = flush_q;
        tmo_d       = tmo_q;
        f_done_d    = 1'b0;
        f_line_d    = '0;
        f_err_d     = 1'b0;
        d_done_d    = 1'b0;
        d_rdata_d   = '0;
        d_err_d     = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        timed_out   = 1'b0;
        rsp_err     = 1'b0;

        // Data wins unless fetch is waiting and has already lost STARVE_MAX times.
        grant_data = d_req && !(f_req && (streak_q == SW'(STARVE_MAX)));

        case (state_q)
            S_IDLE: begin
                flush_d = 1'b0;
                tmo_d   = '0;
                if (f_req || d_req) begin
                    state_d   = S_ISSUE;
                    mem_req_d = 1'b1;
                    if (grant_data) begin
                        owner_d     = 1'b1;
                        we_d        = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (!f_req)
                            streak_d = '0;
                        else if (streak_q != SW'(STARVE_MAX))
                            streak_d = streak_q + 1'b1;
                    end else begin
                        owner_d    = 1'b0;
                        we_d       = 1'b0;
                        mem_addr_d = f_addr;
                        streak_d   = '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                if (mem_rvalid || (tmo_q == TW'(TIMEOUT - 1))) begin
                    state_d   = S_RESP;
                    timed_out = !mem_rvalid;
                    rsp_err   = timed_out || mem_err;
                    if (owner_q) begin
                        d_done_d  = 1'b1;
                        d_err_d   = rsp_err;
                        d_rdata_d = (we_q || timed_out) ? '0 : mem_rdata[DATA_W-1:0];
                    end else if (!(flush_q || f_flush)) begin
                        // A flushed fetch still drains the memory but reports nothing.
                        f_done_d = 1'b1;
                        f_err_d  = rsp_err;
                        f_line_d = timed_out ? '0 : mem_rdata;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && !owner_q && f_flush)
            flush_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            streak_q    <= '0;
            flush_q     <= 1'b0;
            tmo_q       <= '0;
            f_done_q    <= 1'b0;
            f_line_q    <= '0;
            f_err_q     <= 1'b0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            streak_q    <= streak_d;
            flush_q     <= flush_d;
            tmo_q       <= tmo_d;
            f_done_q    <= f_done_d;
            f_line_q    <= f_line_d;
            f_err_q     <= f_err_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign f_done    = f_done_q;
    assign f_line    = f_line_q;
    assign f_err     = f_err_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, f_flush, f_done, f_err;
    logic [63:0] f_addr;
    logic [79:0] f_line;
    logic        d_req, d_we, d_done, d_err;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_rvalid, mem_err;
    logic [63:0] mem_addr, mem_wdata;
    logic [79:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LINE_W(80), .STARVE_MAX(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
        .f_done(f_done), .f_line(f_line), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle mem_req should be high; answers after L cycles and
    // returns in the cycle the done pulse should be visible.
    task automatic serve(input int L, input logic [79:0] rd, input logic er,
                         input logic ewe, input logic [63:0] eaddr, input logic [63:0] ewd);
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_wdata", mem_wdata, ewd);
        repeat (L) step();
        mem_rvalid = 1'b1; mem_rdata = rd; mem_err = er;
        step();
        mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_fdone"}, f_done, 0);
        chk({tag, "_ddone"}, d_done, 0);
        chk({tag, "_mreq"}, mem_req, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwe"}, mem_we, 0);
        chk({tag, "_mwd"}, mem_wdata, 0);
        chk({tag, "_fline"}, f_line, 0);
        chk({tag, "_drd"}, d_rdata, 0);
        chk({tag, "_errs"}, {f_err, d_err}, 0);
    endtask

    // The two done pulses must never coincide.
    always @(negedge clk) if (rst_n === 1'b1) chk("excl_done", f_done & d_done, 0);

    logic [79:0] rd;
    logic [63:0] rd_lo;

    initial begin
        rst_n = 1'b0; f_req = 0; f_addr = 0; f_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        step(); step();
        chk_idle_outs("rst");
        rst_n = 1'b1;
        step();

        // 1: lone fetch, L=2
        f_req = 1; f_addr = 64'h20;
        step();
        serve(2, 80'h30F20A_0123456789ABCD, 1'b0, 1'b0, 64'h20, 64'h0);
        chk("t1_fdone", f_done, 1);
        chk("t1_fline", f_line, 80'h30F20A_0123456789ABCD);
        chk("t1_ferr", f_err, 0);
        chk("t1_ddone", d_done, 0);
        f_req = 0;
        step();
        chk("t1_fdone_off", f_done, 0);

        // 2: fetch and data write together -> data first, then fetch
        f_req = 1; f_addr = 64'h40;
        d_req = 1; d_we = 1; d_addr = 64'h100; d_wdata = 64'hDEAD;
        step();
        serve(1, {80{1'b1}}, 1'b0, 1'b1, 64'h100, 64'hDEAD);
        chk("t2_ddone", d_done, 1);
        chk("t2_drdata_wr", d_rdata, 0);
        chk("t2_fdone", f_done, 0);
        d_req = 0; d_we = 0; d_wdata = 0;
        step();
        chk("t2_gap_mreq", mem_req, 0);
        step();
        serve(3, 80'h1234_5678_9ABC_DEF0_1357, 1'b0, 1'b0, 64'h40, 64'h0);
        chk("t2_fdone", f_done, 1);
        chk("t2_fline", f_line, 80'h1234_5678_9ABC_DEF0_1357);
        chk("t2_ddone2", d_done, 0);
        f_req = 0;
        step();

        // 3: starvation limit: D D D D F D
        f_req = 1; f_addr = 64'h300;
        d_req = 1; d_we = 0; d_addr = 64'h200;
        for (int i = 0; i < 6; i++) begin
            rd = {16'hA5A5, 64'h1111_0000_0000_0000 + 64'(i)};
            rd_lo = rd[63:0];
            step();
            if (i == 4) begin
                serve(1, rd, 1'b0, 1'b0, 64'h300, 64'h0);
                chk("t3_fdone", f_done, 1);
                chk("t3_fline", f_line, rd);
                chk("t3_ddone_f", d_done, 0);
            end else begin
                serve(1, rd, 1'b0, 1'b0, 64'h200, 64'h0);
                chk("t3_ddone", d_done, 1);
                chk("t3_drdata", d_rdata, rd_lo);
                chk("t3_fdone_d", f_done, 0);
            end
            if (i == 5) begin f_req = 0; d_req = 0; end
            step();
        end

        // 4: memory never answers -> timeout 16 cycles after entering WAIT
        d_req = 1; d_we = 0; d_addr = 64'h400;
        step();
        chk("t4_mreq", mem_req, 1);
        for (int c = 2; c <= 17; c++) begin
            step();
            chk("t4_wait_ddone", d_done, 0);
        end
        step();
        chk("t4_ddone", d_done, 1);
        chk("t4_derr", d_err, 1);
        chk("t4_drdata", d_rdata, 0);
        d_req = 0;
        step();
        chk("t4_after", {d_done, mem_req}, 0);

        // 5: flush in WAIT -> no f_done, late rvalid drained, pending data next
        f_req = 1; f_addr = 64'h500;
        step();
        chk("t5_mreq", mem_req, 1);
        chk("t5_maddr", mem_addr, 64'h500);
        step();
        f_flush = 1; f_req = 0;
        d_req = 1; d_we = 0; d_addr = 64'h600;
        step();
        f_flush = 0;
        step(); step();
        mem_rvalid = 1; mem_rdata = 80'hBEEF;
        step();
        mem_rvalid = 0; mem_rdata = 0;
        chk("t5_no_fdone", {f_done, d_done, f_err}, 0);
        step();
        chk("t5_no_fdone2", f_done, 0);
        step();
        rd = 80'hCC_0102030405060708;
        rd_lo = rd[63:0];
        serve(1, rd, 1'b1, 1'b0, 64'h600, 64'h0);
        chk("t5_ddone", d_done, 1);
        chk("t5_drdata", d_rdata, rd_lo);
        chk("t5_derr", d_err, 1);
        d_req = 0;
        step();

        // 6: reset during WAIT, late rvalid ignored, clean restart
        d_req = 1; d_we = 0; d_addr = 64'h700;
        step(); step();
        rst_n = 0;
        step();
        rst_n = 1; d_req = 0;
        mem_rvalid = 1; mem_rdata = 80'h77;
        chk_idle_outs("t6_rst");
        step();
        mem_rvalid = 0; mem_rdata = 0;
        chk("t6_no_done", {f_done, d_done, mem_req}, 0);
        step();
        chk("t6_no_done2", {f_done, d_done, mem_req}, 0);
        d_req = 1; d_we = 1; d_addr = 64'h800; d_wdata = 64'h1234;
        step();
        serve(2, 80'h55, 1'b0, 1'b1, 64'h800, 64'h1234);
        chk("t6_ddone", d_done, 1);
        chk("t6_drdata", d_rdata, 0);
        d_req = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
